// File: rtl/des_f_function.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// des_f_function : two-stage valid/ready DES round f-function, P(S(E(R)^K))
// rev 1.0
// ----------------------------------------------------------------------------
module des_f_function (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out,
  output logic        busy
);

  // One 256-bit table per S-box, entries in row-major reading order, entry 0 at the MSB.
  localparam logic [1:8][255:0] c_sbox = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  // Row = outer bits, column = inner four; entry k sits at bits 255-4k, i.e. {~k, 2'b11}.
  function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] d);
    logic [5:0] idx;
    idx = {d[5], d[0], d[4:1]};
    return tbl[{~idx, 2'b11} -: 4];
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  logic        a_valid_q, a_valid_d;
  logic        b_valid_q, b_valid_d;
  logic [47:0] x_a_q, x_a_d;
  logic [31:0] f_out_q, f_out_d;

  logic [47:0] w_e_r;
  logic [31:0] w_s_a;
  logic        w_b_adv;
  logic        w_in_ready;
  logic        w_in_xfer;

  // Each 6-bit E group is four R bits framed by their circular neighbours.
  for (genvar j = 0; j < 8; j++) begin : g_expand
    assign w_e_r[47-6*j -: 6] = {r_in[(32-4*j) % 32], r_in[31-4*j -: 4], r_in[(59-4*j) % 32]};
  end

  for (genvar i = 1; i <= 8; i++) begin : g_sbox
    assign w_s_a[35-4*i -: 4] = sbox_lookup(c_sbox[i], x_a_q[53-6*i -: 6]);
  end

  always_comb begin
    w_b_adv    = a_valid_q & (~b_valid_q | out_ready);
    w_in_ready = ~a_valid_q | w_b_adv;
    w_in_xfer  = in_valid & w_in_ready;

    a_valid_d = w_in_xfer | (a_valid_q & ~w_b_adv);
    b_valid_d = w_b_adv | (b_valid_q & ~out_ready);
    x_a_d     = x_a_q;
    f_out_d   = f_out_q;
    if (w_in_xfer) x_a_d   = w_e_r ^ subkey;
    if (w_b_adv)   f_out_d = p_perm(w_s_a);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      x_a_q     <= '0;
      f_out_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      x_a_q     <= x_a_d;
      f_out_q   <= f_out_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = b_valid_q;
  assign f_out     = f_out_q;
  assign busy      = a_valid_q | b_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_des_f_function.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_des_f_function : scoreboard bench for the DES f-function pipeline
// rev 1.0
// ----------------------------------------------------------------------------
module tb_des_f_function;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
  logic        busy;

  des_f_function dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] sb_q[$];
  int          pop_cyc_q[$];

  always @(posedge clk) cyc++;

  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Reference f-function walking the tables in DES (1-based, MSB-first) numbering.
  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] f;
    logic [5:0]  c;
    int          row;
    int          col;
    int          v;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]] ^ k[47-i];
    for (int b = 0; b < 8; b++) begin
      c   = x[47-6*b -: 6];
      row = int'({c[5], c[0]});
      col = int'(c[4:1]);
      v   = S_T[b][row*16+col];
      s[31-4*b -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and polices stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_f     = '0;
  logic [31:0] exp_f;
  always @(negedge clk) begin
    #2;
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(out_valid), 64'(1));
        check("stall_hold_data", 64'(f_out), 64'(prev_f));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=no output", f_out);
        end else begin
          exp_f = sb_q.pop_front();
          check("f_out", 64'(f_out), 64'(exp_f));
          pop_cyc_q.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_f     = f_out;
    end
  end

  task automatic offer(input logic [31:0] r, input logic [47:0] k, input logic [31:0] req,
                       input int budget, output int acc_cyc, output int waited);
    bit done;
    done    = 1'b0;
    waited  = 0;
    acc_cyc = -1;
    while (!done && waited < budget) begin
      @(negedge clk);
      r_in     = r;
      subkey   = k;
      in_valid = 1'b1;
      #1;
      if (in_ready) begin
        sb_q.push_back(req);
        acc_cyc = cyc;
        done    = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not accepted required=accepted within %0d cycles", budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n         = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      if ((sb_q.size() == 0 && !busy) || n >= 60) break;
      n++;
    end
    check({name, "_drain_queue"}, 64'(sb_q.size()), 64'(0));
    check({name, "_drain_busy"}, 64'(busy), 64'(0));
  endtask

  localparam logic [31:0] R1 = 32'hF0AAF0AA;
  localparam logic [47:0] K1 = 48'h1B02EFFC7072;
  localparam logic [31:0] F1 = 32'h234AA9BB;
  localparam logic [31:0] R2 = 32'hEF4A6544;
  localparam logic [47:0] K2 = 48'h79AED9DBC9E5;
  localparam logic [31:0] F2 = 32'h3CAB87A3;
  localparam logic [31:0] F0 = 32'hD8D8DBBC;   // R=0, K=0
  localparam logic [47:0] K5 = 48'h000000FC0000;
  localparam logic [31:0] F5 = 32'hF8D8DBBC;   // only S5 sees 111111 -> 3

  initial begin
    int acc;
    int wt;
    int wsum;
    bit seen;
    bit have_vec;
    logic [31:0] rr;
    logic [47:0] kk;

    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; r_in = '0; subkey = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_f_out", 64'(f_out), 64'(0));
    #2 n_rst = 1'b1;

    // Known vector with latency measurement
    offer(R1, K1, F1, 5, acc, wt);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      if (out_valid) begin
        check("latency", 64'(cyc - acc), 64'(2));
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL latency_timeout actual=no out_valid required=out_valid after 2 cycles");
    end
    drain("known");

    // Back-to-back
    pop_cyc_q.delete();
    wsum = 0;
    offer(R1, K1, F1, 5, acc, wt); wsum += wt;
    offer(R2, K2, F2, 5, acc, wt); wsum += wt;
    offer(32'h0, 48'h0, F0, 5, acc, wt); wsum += wt;
    offer(32'h0, K5, F5, 5, acc, wt); wsum += wt;
    drain("b2b");
    check("b2b_in_ready_waits", 64'(wsum), 64'(0));
    check("b2b_count", 64'(pop_cyc_q.size()), 64'(4));
    if (pop_cyc_q.size() == 4) check("b2b_span", 64'(pop_cyc_q[3] - pop_cyc_q[0]), 64'(3));

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        offer(R1, K1, F1, 30, acc, wt);
        offer(32'h0, 48'h0, F0, 30, acc, wt);
        offer(R2, K2, F2, 30, acc, wt);
      end
      begin
        repeat (5) @(negedge clk);
        #3;
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_f_out_hold", 64'(f_out), 64'(F1));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_busy", 64'(busy), 64'(1));
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("bp");

    // Subkey/R changes while A and B hold data must not disturb results
    @(negedge clk);
    out_ready = 1'b0;
    offer(R1, K1, F1, 5, acc, wt);
    offer(32'h0, 48'h0, F0, 5, acc, wt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      r_in     = $urandom;
      subkey   = {$urandom, $urandom};
    end
    drain("keychg");

    // Reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    offer(R1, K1, F1, 5, acc, wt);
    offer(R2, K2, F2, 5, acc, wt);
    idle(1);
    #3 n_rst = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_f_out", 64'(f_out), 64'(0));
    @(negedge clk);
    #3 n_rst = 1'b1;
    out_ready = 1'b1;
    idle(3);
    #3;
    check("postrst_idle_valid", 64'(out_valid), 64'(0));
    pop_cyc_q.delete();
    offer(32'h0, K5, F5, 5, acc, wt);
    drain("postrst");
    check("postrst_count", 64'(pop_cyc_q.size()), 64'(1));

    // Random traffic against the reference model
    have_vec = 1'b0;
    rr = '0;
    kk = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!have_vec) begin
        rr       = $urandom;
        kk       = {$urandom, $urandom};
        have_vec = ($urandom_range(0, 3) != 0);
      end
      in_valid = have_vec;
      r_in     = rr;
      subkey   = kk;
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back(model_f(rr, kk));
        have_vec = 1'b0;
      end
    end
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
